// File: rtl/multicycle_controller.sv
// Main FSM of the multi-cycle RV64I core: sequences fetch/decode/exec/mem/wb and drives datapath strobes.
// Strobes are combinational from state/opcode/zero/ack; state, trap flags, wait counter and retired count are registered.
module multicycle_controller #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int INSTR_COUNT_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_run,
  input  logic [31:0]              i_instruction,
  input  logic                     i_zero,
  output logic                     o_imem_req,
  input  logic                     i_imem_ack,
  output logic                     o_dmem_req,
  input  logic                     i_dmem_ack,
  output logic                     o_mem_write,
  output logic                     o_ir_write,
  output logic                     o_pc_write,
  output logic                     o_pc_branch,
  output logic                     o_alu_src_imm,
  output logic [1:0]               o_alu_op,
  output logic                     o_reg_write,
  output logic                     o_wb_sel,
  output logic [2:0]               o_state,
  output logic                     o_illegal_instr,
  output logic                     o_timeout,
  output logic [INSTR_COUNT_W-1:0] o_retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [2:0]               r_state;
  logic [2:0]               w_next;
  logic [CNT_W-1:0]         r_wait_cnt;
  logic                     r_illegal;
  logic                     r_timeout;
  logic [INSTR_COUNT_W-1:0] r_retired;

  logic [6:0] w_op;
  logic       w_is_r, w_is_i, w_is_ld, w_is_sd, w_is_beq, w_legal;
  logic       w_waiting, w_ack, w_wait_last, w_retire;
  logic [2:0] w_boundary;
  logic       w_unused_instr;

  assign w_op           = i_instruction[6:0];
  assign w_unused_instr = ^i_instruction[31:7];
  assign w_is_r         = (w_op == OP_R);
  assign w_is_i         = (w_op == OP_I);
  assign w_is_ld        = (w_op == OP_LD);
  assign w_is_sd        = (w_op == OP_SD);
  assign w_is_beq       = (w_op == OP_BEQ);
  assign w_legal        = w_is_r | w_is_i | w_is_ld | w_is_sd | w_is_beq;

  // Only one request is ever outstanding, so a single counter covers both memories.
  assign w_waiting   = (r_state == S_FETCH) | (r_state == S_MEM);
  assign w_ack       = (r_state == S_FETCH) ? i_imem_ack : i_dmem_ack;
  assign w_wait_last = (r_wait_cnt == CNT_LAST);
  assign w_boundary  = i_run ? S_FETCH : S_IDLE;
  assign w_retire    = ((r_state == S_EXEC) & w_is_beq) |
                       ((r_state == S_MEM) & i_dmem_ack & w_is_sd) |
                       (r_state == S_WB);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_run) w_next = S_FETCH;
      S_FETCH: begin
        if (i_imem_ack)       w_next = S_DECODE;
        else if (w_wait_last) w_next = S_TRAP;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_is_beq)                w_next = w_boundary;
        else if (w_is_ld || w_is_sd) w_next = S_MEM;
        else                         w_next = S_WB;
      end
      S_MEM: begin
        if (i_dmem_ack)       w_next = w_is_ld ? S_WB : w_boundary;
        else if (w_wait_last) w_next = S_TRAP;
      end
      S_WB:     w_next = w_boundary;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
      r_retired  <= '0;
    end else begin
      if (w_waiting && !w_ack) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else                     r_wait_cnt <= '0;
      if (r_state == S_DECODE && !w_legal)      r_illegal <= 1'b1;
      if (w_waiting && !w_ack && w_wait_last)   r_timeout <= 1'b1;
      if (w_retire) r_retired <= r_retired + INSTR_COUNT_W'(1);
    end
  end

  always_comb begin
    o_imem_req    = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_dmem_req    = 1'b0;
    o_mem_write   = 1'b0;
    o_pc_branch   = 1'b0;
    o_alu_src_imm = 1'b0;
    o_alu_op      = 2'b00;
    o_reg_write   = 1'b0;
    o_wb_sel      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_write = i_imem_ack;
        o_pc_write = i_imem_ack;
      end
      S_EXEC: begin
        if (w_is_r) begin
          o_alu_op = 2'b10;
        end else if (w_is_i) begin
          o_alu_src_imm = 1'b1;
          o_alu_op      = 2'b10;
        end else if (w_is_ld || w_is_sd) begin
          o_alu_src_imm = 1'b1;
        end else if (w_is_beq) begin
          o_alu_op    = 2'b01;
          o_pc_branch = i_zero;
        end
      end
      S_MEM: begin
        o_dmem_req    = 1'b1;
        o_mem_write   = w_is_sd;
        o_alu_src_imm = 1'b1;
      end
      S_WB: begin
        o_reg_write = 1'b1;
        o_wb_sel    = w_is_ld;
      end
      default: ;
    endcase
  end

  assign o_state         = r_state;
  assign o_illegal_instr = r_illegal;
  assign o_timeout       = r_timeout;
  assign o_retired       = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds each instruction's expected cycle trace from the opcode rules and ack latencies.
module tb_multicycle_controller;
  localparam int TMO = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [31:0]   instr = 32'h0;
  logic          imem_req, dmem_req, mem_write, ir_write, pc_write, pc_branch;
  logic          alu_src_imm, reg_write, wb_sel, illegal_instr, timeout;
  logic [1:0]    alu_op;
  logic [2:0]    st;
  logic [CW-1:0] retired;
  logic [10:0]   obs;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_ret = '0;
  bit            in_idle = 1'b1;

  multicycle_controller #(.MEM_TIMEOUT(TMO), .INSTR_COUNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_instruction(instr), .i_zero(zero),
    .o_imem_req(imem_req), .i_imem_ack(imem_ack), .o_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
    .o_mem_write(mem_write), .o_ir_write(ir_write), .o_pc_write(pc_write), .o_pc_branch(pc_branch),
    .o_alu_src_imm(alu_src_imm), .o_alu_op(alu_op), .o_reg_write(reg_write), .o_wb_sel(wb_sel),
    .o_state(st), .o_illegal_instr(illegal_instr), .o_timeout(timeout), .o_retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, ir_write, pc_write, dmem_req, mem_write, pc_branch,
                alu_src_imm, alu_op, reg_write, wb_sel};

  localparam logic [31:0] ADD = 32'h00B50533;
  localparam logic [31:0] LD  = 32'h00833283;
  localparam logic [31:0] SD  = 32'h00B53423;
  localparam logic [31:0] BEQ = 32'h00B50463;

  // 0=R 1=I-ALU 2=LD 3=SD 4=BEQ, -1 unsupported
  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [10:0] pk(input bit ireq, input bit irpc, input bit dreq, input bit mw,
                                     input bit pb, input bit asrc, input logic [1:0] op,
                                     input bit rw, input bit ws);
    return {ireq, irpc, irpc, dreq, mw, pb, asrc, op, rw, ws};
  endfunction

  // Runs one instruction from FETCH (or IDLE) to the next boundary. id/dd<0 = that ack never comes.
  task automatic do_instr(input logic [31:0] ins, input int id, input int dd, input bit z,
                          input bit run_after, input bit rand_run);
    logic [2:0]  est[$];
    logic [10:0] eo[$];
    bit          ai[$];
    bit          ad[$];
    int          kind, n;
    bit          trap_ill, trap_to, last;
    kind = kind_of(ins[6:0]);
    trap_ill = 1'b0;
    trap_to  = 1'b0;
    instr = ins;
    if (in_idle) begin
      est.push_back(3'd0); eo.push_back('0); ai.push_back(1'($urandom)); ad.push_back(1'($urandom));
    end
    n = (id < 0) ? TMO : id + 1;
    for (int k = 0; k < n; k++) begin
      est.push_back(3'd1); ai.push_back(k == id); ad.push_back(1'($urandom));
      eo.push_back(pk(1, k == id, 0, 0, 0, 0, 2'b00, 0, 0));
    end
    if (id < 0) trap_to = 1'b1;
    else begin
      est.push_back(3'd2); eo.push_back('0); ai.push_back(1'($urandom)); ad.push_back(1'($urandom));
      if (kind < 0) trap_ill = 1'b1;
      else begin
        est.push_back(3'd3); ai.push_back(1'($urandom)); ad.push_back(1'($urandom));
        case (kind)
          0:       eo.push_back(pk(0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
          1:       eo.push_back(pk(0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
          4:       eo.push_back(pk(0, 0, 0, 0, z, 0, 2'b01, 0, 0));
          default: eo.push_back(pk(0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
        endcase
        if (kind == 2 || kind == 3) begin
          n = (dd < 0) ? TMO : dd + 1;
          for (int k = 0; k < n; k++) begin
            est.push_back(3'd4); ad.push_back(k == dd); ai.push_back(1'($urandom));
            eo.push_back(pk(0, 0, 1, kind == 3, 0, 1, 2'b00, 0, 0));
          end
          if (dd < 0) trap_to = 1'b1;
        end
        if (!trap_to && kind <= 2) begin
          est.push_back(3'd5); eo.push_back(pk(0, 0, 0, 0, 0, 0, 2'b00, 1, kind == 2));
          ai.push_back(1'($urandom)); ad.push_back(1'($urandom));
        end
      end
    end
    for (int i = 0; i < est.size(); i++) begin
      last = (i == est.size() - 1) && !trap_ill && !trap_to;
      imem_ack = ai[i];
      dmem_ack = ad[i];
      zero = (est[i] == 3'd3) ? z : 1'($urandom);
      if (last)                run = run_after;
      else if (est[i] == 3'd0) run = 1'b1;
      else if (rand_run)       run = 1'($urandom);
      else                     run = (est[i] < 3'd3) ? 1'b1 : run_after;
      @(negedge clk);
      checks++;
      if (st !== est[i]) begin
        errors++; $display("FAIL state[%0d] ins=%h: got %0d want %0d", i, ins, st, est[i]);
      end
      checks++;
      if (obs !== eo[i]) begin
        errors++; $display("FAIL strobes[%0d] ins=%h st=%0d: got %b want %b", i, ins, est[i], obs, eo[i]);
      end
      @(posedge clk); #1;
    end
    if (trap_ill || trap_to) begin
      for (int c = 0; c < 20; c++) begin
        run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; zero = 1'($urandom);
        @(negedge clk);
        checks++;
        if (st !== 3'd7 || obs !== '0) begin
          errors++; $display("FAIL trap_hold[%0d]: got st=%0d strobes=%b want st=7 strobes=0", c, st, obs);
        end
        @(posedge clk); #1;
      end
    end else begin
      exp_ret = exp_ret + 1'b1;
      in_idle = !run_after;
    end
    checks++;
    if (st !== (trap_ill || trap_to ? 3'd7 : (run_after ? 3'd1 : 3'd0))) begin
      errors++; $display("FAIL end_state ins=%h: got %0d run_after=%0d trap=%0d", ins, st, run_after, trap_ill | trap_to);
    end
    checks++;
    if (illegal_instr !== trap_ill || timeout !== trap_to) begin
      errors++; $display("FAIL flags ins=%h: got ill=%b to=%b want ill=%b to=%b", ins, illegal_instr, timeout, trap_ill, trap_to);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL retired ins=%h: got %0d want %0d", ins, retired, exp_ret);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if (st !== 3'd0 || obs !== '0 || retired !== '0 || illegal_instr !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset: got st=%0d strobes=%b ret=%0d ill=%b to=%b want all 0", st, obs, retired, illegal_instr, timeout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; exp_ret = '0; in_idle = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      run = 1'b0; imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      @(negedge clk);
      checks++;
      if (st !== 3'd0 || obs !== '0) begin
        errors++; $display("FAIL idle_hold[%0d]: got st=%0d strobes=%b want 0", c, st, obs);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    do_instr(ADD, 0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_load();
    do_instr(LD, 0, 3, 1'b0, 1'b1, 1'b0);
    do_instr(LD, $urandom_range(1, 5), 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_store_branch();
    do_instr(SD, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr(BEQ, 0, 0, 1'b1, 1'b1, 1'b0);
    do_instr(BEQ, 2, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_run_drop();
    do_instr(ADD, 1, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h00150513, 0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [5];
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011;
    for (int t = 0; t < 40; t++) begin
      do_instr({25'($urandom), ops[$urandom_range(0, 4)]}, $urandom_range(0, TMO - 1),
               $urandom_range(0, TMO - 1), 1'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    end
  endtask

  task automatic test_timeout_edge();
    do_instr(ADD, TMO - 1, 0, 1'b0, 1'b1, 1'b0);
    do_instr(LD, 0, TMO - 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    logic [6:0] op;
    do_reset();
    do_instr(32'h0000007F, 0, 0, 1'b0, 1'b1, 1'b0);
    do_reset();
    op = 7'($urandom_range(0, 127));
    if (kind_of(op) >= 0) op = 7'h7F;
    do_instr({25'($urandom), op}, 1, 0, 1'b0, 1'b1, 1'b1);
    do_reset();
  endtask

  task automatic test_mem_timeout();
    do_reset();
    do_instr(ADD, -1, 0, 1'b0, 1'b1, 1'b0);
    do_reset();
    do_instr(ADD, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr(LD, 0, -1, 1'b0, 1'b1, 1'b0);
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    do_instr(ADD, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr(ADD, 0, 0, 1'b0, 1'b1, 1'b0);
    instr = LD; run = 1'b1; imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if (st !== 3'd4) begin
      errors++; $display("FAIL pre_reset_mem: got st=%0d want 4", st);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 3'd0 || obs !== '0 || retired !== '0) begin
      errors++; $display("FAIL reset_mid_mem: got st=%0d strobes=%b ret=%0d want 0", st, obs, retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; exp_ret = '0; in_idle = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_load();
    test_store_branch();
    test_run_drop();
    test_back_to_back();
    test_timeout_edge();
    test_illegal();
    test_mem_timeout();
    test_reset_mid_mem();
    test_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
